tcdm_downcast: RTL and testbench
================================

# tcdm_downcast

Width adapter from a wide TCDM initiator to a narrow TCDM target: it accepts one WIDE_WIDTH request at a time and issues it as a sequence of NARROW_WIDTH beats on the narrow port. For reads, it reassembles the narrow responses into one wide response. It is the converse of the narrow-to-wide upcast and sits between a wide-datapath engine (DMA, vector unit) and narrow TCDM banks or legacy peripherals.

## Interface
- WIDE_WIDTH, 64, data width of the wide (initiator-facing) port in bits.
- NARROW_WIDTH, 16, data width of the narrow (target-facing) port in bits.
- ADDR_WIDTH, 32, byte-address width on both ports.
- Derived values:
  - N = WIDE_WIDTH/NARROW_WIDTH.
  - NB = NARROW_WIDTH/8.
  - WB = WIDE_WIDTH/8.
- Elaboration `$error` if any of the following holds:
  - N < 2;
  - N is not a power of two;
  - NARROW_WIDTH is not a multiple of 8.
- Ports (clock and reset first):
  - clk_i  in  1  clock; all state updates on its rising edge.
  - reset_i  in  1  synchronous, active-high reset.
  - tcdm_master  mem_intf.slave  wide  req/gnt/addr/wen/data[WIDE_WIDTH]/be[WB]/r_data[WIDE_WIDTH]/r_valid/r_ready.
  - tcdm_slave  mem_intf.master  narrow  same signals at NARROW_WIDTH/NB.
- Interface encodings:
  - wen=1 is a write; wen=0 is a read.
  - Only reads produce r_valid responses.

## Operation
- FSM states: IDLE, ISSUE, WAIT_R, RESP.
- IDLE
  - tcdm_master.gnt=1.
  - On tcdm_master.req: capture addr (low log2(WB) bits forced to 0), wen, data and be into holding registers.
  - Clear the wide read buffer and both counters, compute the beat-enable mask, then go to ISSUE.
- Beat-enable mask: beat k is enabled if its be slice be[k*NB +: NB] is non-zero, or if the skip feature is compiled out (see Configuration).
- ISSUE
  - issue_idx advances to the next enabled beat k (ascending order).
  - Narrow port drives the following for beat k:
    - tcdm_slave.req=1;
    - addr = captured wide addr + k*NB;
    - wen = captured wen;
    - data = data[k*NARROW_WIDTH +: NARROW_WIDTH];
    - be = be slice k.
  - Advance on tcdm_slave.req & tcdm_slave.gnt.
  - req, addr and data are held stable until gnt.
  - After the last enabled beat is granted:
    - write → IDLE;
    - read with all responses already received → RESP;
    - otherwise → WAIT_R.
- Read collection (ISSUE and WAIT_R)
  - tcdm_slave.r_ready=1 in ISSUE and WAIT_R only.
  - Narrow responses arrive in issue order.
  - resp_idx walks the enabled-beat list; each r_valid writes r_data into lane resp_idx of the wide buffer.
  - WAIT_R → RESP when the final response is received.
- RESP
  - tcdm_master.r_valid=1 and r_data = wide buffer.
  - Disabled lanes read as 0.
  - On r_ready → IDLE.
- Simultaneous events:
  - A narrow gnt for the last beat and an r_valid for an earlier beat in the same cycle are both honoured.
  - A grant and a response for the same beat in one cycle are accepted.
- Write with zero total mask (skip enabled): accepted in IDLE, no narrow beats, returns to IDLE the next cycle.
- Read with zero total mask (skip enabled): goes directly to RESP with r_data=0.
- tcdm_master.gnt=0 in every state except IDLE, so only one wide transaction is in flight.

## Timing
- Reset values of outputs:
  - tcdm_master.gnt=1 (IDLE);
  - tcdm_master.r_valid=0;
  - tcdm_master.r_data=0;
  - tcdm_slave.req=0;
  - tcdm_slave.r_ready=0;
  - tcdm_slave addr/data/be/wen=0.
- Wide acceptance at cycle T (req&gnt) → first narrow req at T+1.
- Write with M enabled beats and zero-wait gnt:
  - narrow req in T+1..T+M;
  - IDLE (gnt=1) at T+M+1.
- Read with narrow response latency L cycles after grant: tcdm_master.r_valid is asserted the cycle after the last narrow r_valid.
- Back-pressure:
  - RESP holds r_valid/r_data stable until r_ready.
  - narrow gnt=0 stalls ISSUE with all signals stable.
- Reset mid-operation: returns to IDLE with the buffer cleared. Narrow-side responses still outstanding are dropped (r_ready=0). The narrow target must be reset in the same cycle.

## Configuration
- TCDM_DOWNCAST_SKIP_EMPTY_EN
  - Defined: beats whose be slice is all-zero are not issued. For reads, those lanes return 0.
  - Undefined: all N beats are always issued in order 0..N-1 with their be slice passed through, including zero slices. A zero-total-mask write takes N beats.

## Test plan
- Full write, WIDE=64/NARROW=16, addr=0x104, data=0x4444_3333_2222_1111, be=0xFF, gnt always 1:
  - narrow writes to 0x100/0x102/0x104/0x106 with data 0x1111..0x4444, be=0x3;
  - wide gnt returns at acceptance+5.
- Full read, narrow target returning 0xAAAA,0xBBBB,0xCCCC,0xDDDD with L=2 → wide r_data=0xDDDD_CCCC_BBBB_AAAA, r_valid one cycle after the last narrow r_valid.
- Sparse read with be=0x0C:
  - skip defined: one narrow read at addr+2 returning 0x5A5A → r_data=0x0000_0000_5A5A_0000;
  - skip undefined: 4 narrow reads issued.
- Narrow gnt held 0 for 3 cycles on beat 1 of a write: addr, data and be stay stable, no beat is duplicated, and total beats = 4.
- Wide r_ready held 0 for 5 cycles in RESP: r_valid and r_data stay stable, gnt stays 0, and the next request is accepted one cycle after r_ready.
- reset_i asserted during WAIT_R: the next cycle shows gnt=1, r_valid=0, narrow req=0, and a subsequent full read completes correctly.

Source files
------------

// File: rtl/tcdm_downcast.sv
// -----------------------------------------------------------------------------
// tcdm_downcast
//   Width adapter from a wide TCDM initiator to a narrow TCDM target. It
//   accepts one wide request at a time and replays it as a series of narrow
//   beats. For reads it collects the narrow responses into one wide response.
//
// Optional feature macro: TCDM_DOWNCAST_SKIP_EMPTY_EN
//   Defined   : beats whose byte-enable slice is all zero are not issued, and
//               their read lanes return 0.
//   Undefined : all N beats are always issued in order 0..N-1.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   tcdm_master_*             wide side (this block is the target)
//     req_i/gnt_o             request handshake (gnt_o high only in IDLE)
//     addr_i/wen_i/data_i/be_i request fields (wen=1 write, wen=0 read)
//     r_data_o/r_valid_o/r_ready_i  read response channel
//   tcdm_slave_*              narrow side (this block is the initiator)
//     req_o/gnt_i             per-beat request handshake
//     addr_o/wen_o/data_o/be_o beat fields
//     r_data_i/r_valid_i/r_ready_o  narrow read responses, in issue order
// -----------------------------------------------------------------------------
module tcdm_downcast #(
  parameter int unsigned WIDE_WIDTH   = 64,
  parameter int unsigned NARROW_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  // wide initiator-facing port
  input  logic                      tcdm_master_req_i,
  output logic                      tcdm_master_gnt_o,
  input  logic [ADDR_WIDTH-1:0]     tcdm_master_addr_i,
  input  logic                      tcdm_master_wen_i,
  input  logic [WIDE_WIDTH-1:0]     tcdm_master_data_i,
  input  logic [WIDE_WIDTH/8-1:0]   tcdm_master_be_i,
  output logic [WIDE_WIDTH-1:0]     tcdm_master_r_data_o,
  output logic                      tcdm_master_r_valid_o,
  input  logic                      tcdm_master_r_ready_i,
  // narrow target-facing port
  output logic                      tcdm_slave_req_o,
  input  logic                      tcdm_slave_gnt_i,
  output logic [ADDR_WIDTH-1:0]     tcdm_slave_addr_o,
  output logic                      tcdm_slave_wen_o,
  output logic [NARROW_WIDTH-1:0]   tcdm_slave_data_o,
  output logic [NARROW_WIDTH/8-1:0] tcdm_slave_be_o,
  input  logic [NARROW_WIDTH-1:0]   tcdm_slave_r_data_i,
  input  logic                      tcdm_slave_r_valid_i,
  output logic                      tcdm_slave_r_ready_o
);

  localparam int unsigned N  = WIDE_WIDTH / NARROW_WIDTH;
  localparam int unsigned NB = NARROW_WIDTH / 8;
  localparam int unsigned WB = WIDE_WIDTH / 8;
  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;
  // Beat indices carry one extra bit so the value N can mean "no more beats".
  localparam int unsigned IW = LW + 1;
  localparam logic [IW-1:0] IDX_END = IW'(N);

  if (N < 2) begin : g_err_ratio
    $error("tcdm_downcast: WIDE_WIDTH/NARROW_WIDTH must be at least 2");
  end
  if ((N & (N - 1)) != 0) begin : g_err_pow2
    $error("tcdm_downcast: WIDE_WIDTH/NARROW_WIDTH must be a power of two");
  end
  if ((NARROW_WIDTH % 8) != 0) begin : g_err_bytes
    $error("tcdm_downcast: NARROW_WIDTH must be a multiple of 8");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           issue_idx_q, issue_idx_d;
  logic [IW-1:0]           resp_idx_q, resp_idx_d;
  logic [N-1:0]            mask_q, mask_d;
  logic [WIDE_WIDTH-1:0]   buf_q, buf_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [WIDE_WIDTH-1:0]   data_q, data_d;
  logic [WB-1:0]           be_q, be_d;

  logic [IW-1:0]           first_idx;
  logic [IW-1:0]           nxt_issue;
  logic [LW-1:0]           issue_lane;
  logic [LW-1:0]           resp_lane;

  // Lowest enabled beat at or above 'from'; IDX_END when none is left.
  function automatic logic [IW-1:0] next_en(input logic [N-1:0] m,
                                            input logic [IW-1:0] from);
    logic [IW-1:0] r;
    r = IDX_END;
    for (int k = N - 1; k >= 0; k--) begin
      if (m[k] && (k >= int'(from))) r = IW'(k);
    end
    return r;
  endfunction

`ifdef TCDM_DOWNCAST_SKIP_EMPTY_EN
  function automatic logic [N-1:0] beat_mask(input logic [WB-1:0] be);
    logic [N-1:0] m;
    for (int k = 0; k < N; k++) m[k] = |be[k*NB +: NB];
    return m;
  endfunction
`endif

  assign issue_lane = issue_idx_q[LW-1:0];
  assign resp_lane  = resp_idx_q[LW-1:0];

  always_comb begin
    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    resp_idx_d  = resp_idx_q;
    mask_d      = mask_q;
    buf_d       = buf_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    data_d      = data_q;
    be_d        = be_q;
    first_idx   = IDX_END;
    nxt_issue   = IDX_END;

    tcdm_master_gnt_o     = 1'b0;
    tcdm_master_r_valid_o = 1'b0;
    tcdm_master_r_data_o  = '0;
    tcdm_slave_req_o      = 1'b0;
    tcdm_slave_addr_o     = '0;
    tcdm_slave_wen_o      = 1'b0;
    tcdm_slave_data_o     = '0;
    tcdm_slave_be_o       = '0;
    tcdm_slave_r_ready_o  = 1'b0;

    // Response collection runs alongside issuing, so a grant for the last
    // beat and a response for an earlier beat in one cycle are both taken.
    if ((state_q == ISSUE) || (state_q == WAIT_R)) begin
      tcdm_slave_r_ready_o = 1'b1;
      if (!wen_q && tcdm_slave_r_valid_i && (resp_idx_q != IDX_END)) begin
        buf_d[32'(resp_lane)*NARROW_WIDTH +: NARROW_WIDTH] = tcdm_slave_r_data_i;
        resp_idx_d = next_en(mask_q, resp_idx_q + IW'(1));
      end
    end

    case (state_q)
      IDLE: begin
        tcdm_master_gnt_o = 1'b1;
        if (tcdm_master_req_i) begin
          addr_d = tcdm_master_addr_i & ~ADDR_WIDTH'(WB - 1);
          wen_d  = tcdm_master_wen_i;
          data_d = tcdm_master_data_i;
          be_d   = tcdm_master_be_i;
`ifdef TCDM_DOWNCAST_SKIP_EMPTY_EN
          mask_d = beat_mask(tcdm_master_be_i);
`else
          mask_d = '1;
`endif
          buf_d       = '0;
          first_idx   = next_en(mask_d, '0);
          issue_idx_d = first_idx;
          resp_idx_d  = first_idx;
          // An empty write completes on acceptance; an empty read answers 0.
          if (first_idx != IDX_END)  state_d = ISSUE;
          else if (!tcdm_master_wen_i) state_d = RESP;
        end
      end
      ISSUE: begin
        tcdm_slave_req_o  = 1'b1;
        tcdm_slave_addr_o = addr_q + ADDR_WIDTH'(32'(issue_lane) * NB);
        tcdm_slave_wen_o  = wen_q;
        tcdm_slave_data_o = data_q[32'(issue_lane)*NARROW_WIDTH +: NARROW_WIDTH];
        tcdm_slave_be_o   = be_q[32'(issue_lane)*NB +: NB];
        if (tcdm_slave_gnt_i) begin
          nxt_issue = next_en(mask_q, issue_idx_q + IW'(1));
          if (nxt_issue != IDX_END) begin
            issue_idx_d = nxt_issue;
          end else begin
            issue_idx_d = IDX_END;
            if (wen_q)                     state_d = IDLE;
            else if (resp_idx_d == IDX_END) state_d = RESP;
            else                           state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (resp_idx_d == IDX_END) state_d = RESP;
      end
      RESP: begin
        tcdm_master_r_valid_o = 1'b1;
        tcdm_master_r_data_o  = buf_q;
        if (tcdm_master_r_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and the response buffer are cleared by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      issue_idx_q <= '0;
      resp_idx_q  <= '0;
      mask_q      <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      resp_idx_q  <= resp_idx_d;
      mask_q      <= mask_d;
      buf_q       <= buf_d;
    end
  end

  // Request holding registers only load in IDLE and never reach an output
  // outside ISSUE, so they need no reset.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    wen_q  <= wen_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

endmodule

// File: tb/tb_tcdm_downcast.sv
module tb_tcdm_downcast;

  localparam int N  = 4;
  localparam int NW = 16;
`ifdef TCDM_DOWNCAST_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [15:0] data;
    logic [1:0]  be;
  } beat_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        m_req, m_gnt, m_wen, m_rvalid, m_rready;
  logic [31:0] m_addr;
  logic [63:0] m_data, m_rdata;
  logic [7:0]  m_be;
  logic        s_req, s_wen, s_rready;
  logic        s_gnt = 1'b0;
  logic        s_rvalid = 1'b0;
  logic [15:0] s_rdata = 16'h0;
  logic [31:0] s_addr;
  logic [15:0] s_data;
  logic [1:0]  s_be;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rv_cyc = -1;
  int lat_cfg = 2;
  int stall_beat = -1;
  int stall_left = 0;
  bit rand_gnt = 1'b0;
  beat_t beats[$];
  rsp_t  rq[$];
  logic [15:0] nmem [0:255];

  always #5 clk = ~clk;

  tcdm_downcast dut (
    .clk_i                 (clk),
    .reset_i               (reset_i),
    .tcdm_master_req_i     (m_req),
    .tcdm_master_gnt_o     (m_gnt),
    .tcdm_master_addr_i    (m_addr),
    .tcdm_master_wen_i     (m_wen),
    .tcdm_master_data_i    (m_data),
    .tcdm_master_be_i      (m_be),
    .tcdm_master_r_data_o  (m_rdata),
    .tcdm_master_r_valid_o (m_rvalid),
    .tcdm_master_r_ready_i (m_rready),
    .tcdm_slave_req_o      (s_req),
    .tcdm_slave_gnt_i      (s_gnt),
    .tcdm_slave_addr_o     (s_addr),
    .tcdm_slave_wen_o      (s_wen),
    .tcdm_slave_data_o     (s_data),
    .tcdm_slave_be_o       (s_be),
    .tcdm_slave_r_data_i   (s_rdata),
    .tcdm_slave_r_valid_i  (s_rvalid),
    .tcdm_slave_r_ready_o  (s_rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'(a[8:1]);
  endfunction

  function automatic bit lane_en(input logic [7:0] be, input int k);
    return !SKIP || (be[2*k +: 2] != 2'b00);
  endfunction

  // Narrow target: memory with in-order read responses lat_cfg cycles after grant.
  always begin : responder
    bit    do_gnt, do_rsp, was_rst, hold_vld;
    beat_t b, hold_b;
    @(negedge clk);
    #4;
    do_gnt  = s_req && s_gnt;
    do_rsp  = s_rvalid && s_rready;
    was_rst = reset_i;
    b = '{s_addr, s_wen, s_data, s_be};
    if (hold_vld) begin
      check("stall_req",  64'(s_req), 64'(1));
      check("stall_addr", 64'(b.addr), 64'(hold_b.addr));
      check("stall_data", 64'(b.data), 64'(hold_b.data));
      check("stall_be",   64'(b.be),   64'(hold_b.be));
    end
    hold_vld = s_req && !s_gnt && !was_rst;
    hold_b   = b;
    @(posedge clk);
    cyc++;
    if (was_rst) begin
      rq.delete();
    end else begin
      if (do_rsp && rq.size() > 0) begin
        void'(rq.pop_front());
        last_rv_cyc = cyc;
      end
      if (do_gnt) begin
        beats.push_back(b);
        if (b.wen) begin
          for (int bb = 0; bb < 2; bb++)
            if (b.be[bb]) nmem[midx(b.addr)][8*bb +: 8] = b.data[8*bb +: 8];
        end else begin
          rq.push_back('{cyc + lat_cfg, nmem[midx(b.addr)]});
        end
      end
    end
    #1;
    if (s_req && stall_left > 0 && beats.size() == stall_beat) begin
      s_gnt = 1'b0;
      stall_left--;
    end else if (rand_gnt) begin
      s_gnt = ($urandom_range(0, 2) != 0);
    end else begin
      s_gnt = 1'b1;
    end
    if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
      s_rvalid = 1'b1;
      s_rdata  = rq[0].data;
    end else begin
      s_rvalid = 1'b0;
      s_rdata  = 16'($urandom);
    end
  end

  // One wide transaction, checked against the beat list and read data that
  // follow from the request and the narrow memory contents.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic wen,
                         input logic [63:0] data, input logic [7:0] be,
                         input int rdelay, input bit chk_wr_timing,
                         output logic [63:0] rd_obs);
    beat_t       exp_q[$];
    logic [63:0] exp_rd;
    logic [31:0] base;
    int          t_acc, tmo;
    base   = addr & ~32'h7;
    exp_rd = 64'h0;
    rd_obs = 64'h0;
    for (int k = 0; k < N; k++) begin
      if (lane_en(be, k)) begin
        exp_q.push_back('{base + 32'(2*k), wen, data[16*k +: 16], be[2*k +: 2]});
        if (!wen) exp_rd[16*k +: 16] = nmem[midx(base + 32'(2*k))];
      end
    end
    beats.delete();
    tmo = 0;
    while (!m_gnt && tmo < 200) begin @(negedge clk); tmo++; end
    check({tag, "_idle_gnt"}, 64'(m_gnt), 64'(1));
    m_req = 1'b1; m_addr = addr; m_wen = wen; m_data = data; m_be = be;
    t_acc = cyc + 1;
    @(negedge clk);
    m_req = 1'b0; m_addr = $urandom; m_data = {$urandom, $urandom}; m_be = 8'($urandom);
    tmo = 0;
    if (wen) begin
      while (!m_gnt && tmo < 200) begin @(negedge clk); tmo++; end
      check({tag, "_wr_done"}, 64'(m_gnt), 64'(1));
      if (chk_wr_timing)
        check({tag, "_wr_cycles"}, 64'(cyc + 1 - t_acc), 64'(exp_q.size() + 1));
    end else begin
      while (!m_rvalid && tmo < 200) begin @(negedge clk); tmo++; end
      check({tag, "_rvalid"}, 64'(m_rvalid), 64'(1));
      if (exp_q.size() > 0)
        check({tag, "_rvalid_cycle"}, 64'(cyc), 64'(last_rv_cyc));
      rd_obs = m_rdata;
      check({tag, "_rdata"}, m_rdata, exp_rd);
      for (int i = 0; i < rdelay; i++) begin
        @(negedge clk);
        check({tag, "_hold_rvalid"}, 64'(m_rvalid), 64'(1));
        check({tag, "_hold_rdata"}, m_rdata, rd_obs);
        check({tag, "_hold_gnt"}, 64'(m_gnt), 64'(0));
      end
      m_rready = 1'b1;
      @(negedge clk);
      m_rready = 1'b0;
      check({tag, "_post_gnt"}, 64'(m_gnt), 64'(1));
      check({tag, "_post_rvalid"}, 64'(m_rvalid), 64'(0));
    end
    check({tag, "_nbeats"}, 64'(beats.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
      check({tag, "_beat_addr"}, 64'(beats[i].addr), 64'(exp_q[i].addr));
      check({tag, "_beat_wen"},  64'(beats[i].wen),  64'(exp_q[i].wen));
      check({tag, "_beat_data"}, 64'(beats[i].data), 64'(exp_q[i].data));
      check({tag, "_beat_be"},   64'(beats[i].be),   64'(exp_q[i].be));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [63:0] rd;
    int          tmo;
    for (int i = 0; i < 256; i++) nmem[i] = 16'($urandom);
    reset_i = 1'b1; m_req = 1'b0; m_addr = '0; m_wen = 1'b0; m_data = '0; m_be = '0;
    m_rready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt",    64'(m_gnt),    64'(1));
    check("rst_rvalid", 64'(m_rvalid), 64'(0));
    check("rst_rdata",  m_rdata,       64'h0);
    check("rst_sreq",   64'(s_req),    64'(0));
    check("rst_srready",64'(s_rready), 64'(0));
    check("rst_saddr",  64'(s_addr),   64'(0));
    check("rst_sdata",  64'(s_data),   64'(0));
    check("rst_sbe",    64'(s_be),     64'(0));
    check("rst_swen",   64'(s_wen),    64'(0));
    reset_i = 1'b0;
    @(negedge clk);

    // full write, zero-wait grants
    run_txn("full_wr", 32'h104, 1'b1, 64'h4444_3333_2222_1111, 8'hFF, 0, 1'b1, rd);

    // full read with latency 2
    nmem[midx(32'h100)] = 16'hAAAA; nmem[midx(32'h102)] = 16'hBBBB;
    nmem[midx(32'h104)] = 16'hCCCC; nmem[midx(32'h106)] = 16'hDDDD;
    lat_cfg = 2;
    run_txn("full_rd", 32'h100, 1'b0, 64'h0, 8'hFF, 0, 1'b0, rd);
    check("full_rd_const", rd, 64'hDDDD_CCCC_BBBB_AAAA);

    // sparse read
    nmem[midx(32'h202)] = 16'h5A5A;
    run_txn("sparse_rd", 32'h200, 1'b0, 64'h0, 8'h0C, 0, 1'b0, rd);

    // narrow gnt stalled for 3 cycles on beat 1 of a write
    stall_beat = 1; stall_left = 3;
    run_txn("stall_wr", 32'h40, 1'b1, 64'h8765_4321_0FED_CBA9, 8'hFF, 0, 1'b0, rd);
    check("stall_consumed", 64'(stall_left), 64'(0));
    stall_beat = -1;

    // wide r_ready held low for 5 cycles
    lat_cfg = 1;
    run_txn("bp_rd", 32'h48, 1'b0, 64'h0, 8'hFF, 5, 1'b0, rd);

    // zero-mask transactions
    run_txn("zero_wr", 32'h80, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'h00, 0, 1'b1, rd);
    run_txn("zero_rd", 32'h80, 1'b0, 64'h0, 8'h00, 0, 1'b0, rd);

    // reset while waiting for narrow read responses
    lat_cfg = 8;
    beats.delete();
    m_req = 1'b1; m_addr = 32'h300; m_wen = 1'b0; m_be = 8'hFF; m_data = '0;
    @(negedge clk);
    m_req = 1'b0;
    tmo = 0;
    while (beats.size() < 4 && tmo < 200) begin @(negedge clk); tmo++; end
    check("wr_rst_beats", 64'(beats.size()), 64'(4));
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("mid_rst_gnt",    64'(m_gnt),    64'(1));
    check("mid_rst_rvalid", 64'(m_rvalid), 64'(0));
    check("mid_rst_rdata",  m_rdata,       64'h0);
    check("mid_rst_sreq",   64'(s_req),    64'(0));
    check("mid_rst_rready", 64'(s_rready), 64'(0));
    lat_cfg = 2;
    run_txn("post_rst_rd", 32'h300, 1'b0, 64'h0, 8'hFF, 0, 1'b0, rd);

    // randomized traffic with random narrow grants, latency and back-pressure
    rand_gnt = 1'b1;
    for (int t = 0; t < 40; t++) begin
      lat_cfg = $urandom_range(1, 4);
      run_txn("rand", $urandom, 1'($urandom), {$urandom, $urandom}, 8'($urandom),
              $urandom_range(0, 2), 1'b0, rd);
    end
    rand_gnt = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
